// File: rtl/comunicaciones_pkg.sv
// Shared types and constants for the command/data UART link to the J1 SoC.
// Holds the receiver and frame-parser state encodings and the default bit period.
// No ports; imported by uart_rx_byte and recibir_trama.
package comunicaciones_pkg;

  // 50 MHz / 9600 baud; shared with the transmit path so both ends agree.
  localparam int CLKS_PER_BIT_DEF = 5208;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  typedef enum logic {
    WAIT_CMD,
    WAIT_DAT
  } parse_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: two-flop synchroniser, start/data/stop FSM and bit timer.
// Ports: clk, rst (async active-low), rx (async serial in) ->
//        byte_ok / stop_err (one-cycle pulses), rx_byte[7:0], active (FSM not idle).
module uart_rx_byte
  import comunicaciones_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_ok,
  output logic [7:0] rx_byte,
  output logic       stop_err,
  output logic       active
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     state_q, state_d;
  logic          rx_s1, rx_s;
  logic [TW-1:0] timer_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shreg;
  logic          tick;

  assign tick    = (timer_q == '0);
  assign active  = (state_q != IDLE);
  assign rx_byte = shreg;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!rx_s) state_d = START;
      // A start bit that is high again at mid-bit was only a glitch.
      START: if (tick) state_d = rx_s ? IDLE : DATA;
      DATA:  if (tick && bit_idx_q == 3'd7) state_d = STOP;
      // Leave at the mid-point of the stop bit so a back-to-back start is caught.
      STOP:  if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1     <= 1'b1;
      rx_s      <= 1'b1;
      state_q   <= IDLE;
      timer_q   <= HALF;
      bit_idx_q <= 3'd0;
      shreg     <= 8'h00;
      byte_ok   <= 1'b0;
      stop_err  <= 1'b0;
    end else begin
      rx_s1    <= rx;
      rx_s     <= rx_s1;
      state_q  <= state_d;
      byte_ok  <= 1'b0;
      stop_err <= 1'b0;

      // Timer preloads a half period while idle, then reloads a full period on each sample.
      if (state_q == IDLE)
        timer_q <= HALF;
      else if (tick)
        timer_q <= FULL;
      else
        timer_q <= timer_q - 1'b1;

      if (state_q == DATA && tick) begin
        shreg     <= {rx_s, shreg[7:1]};
        bit_idx_q <= bit_idx_q + 1'b1;  // wraps 7 -> 0 on entry to STOP
      end

      if (state_q == STOP && tick) begin
        byte_ok  <= rx_s;
        stop_err <= ~rx_s;
      end
    end
  end

endmodule

// File: rtl/recibir_trama.sv
// UART receiver + two-byte (command, data) frame parser for the J1 return path.
// Ports: clk, rst (async active-low), rx, ack -> comando_rx, datos_rx, valid,
//        overrun, frame_err (sticky until ack), bussy. Optional RECIBIR_TRAMA_TIMEOUT_EN.
module recibir_trama
  import comunicaciones_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       ack,
  output logic [7:0] comando_rx,
  output logic [7:0] datos_rx,
  output logic       valid,
  output logic       overrun,
  output logic       frame_err,
  output logic       bussy
);

  parse_state_t pstate_q, pstate_d;
  logic         byte_ok, stop_err, active, timeout, frame_done, clr;
  logic [7:0]   rx_byte, cmd_hold;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .byte_ok  (byte_ok),
    .rx_byte  (rx_byte),
    .stop_err (stop_err),
    .active   (active)
  );

  assign clr   = ack & valid;
  assign bussy = active | (pstate_q == WAIT_DAT);

`ifdef RECIBIR_TRAMA_TIMEOUT_EN
  // Drops a lone command byte if its data byte never starts arriving.
  localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TOW       = $clog2(TO_CYCLES + 1);
  logic [TOW-1:0] to_cnt;

  assign timeout = (pstate_q == WAIT_DAT) && !active && (to_cnt == TOW'(TO_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      to_cnt <= '0;
    else if (pstate_q == WAIT_DAT && !active)
      to_cnt <= timeout ? '0 : to_cnt + 1'b1;
    else
      to_cnt <= '0;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    pstate_d   = pstate_q;
    frame_done = 1'b0;
    if (stop_err) begin
      pstate_d = WAIT_CMD;
    end else begin
      case (pstate_q)
        WAIT_CMD: if (byte_ok) pstate_d = WAIT_DAT;
        WAIT_DAT: begin
          if (byte_ok) begin
            frame_done = 1'b1;
            pstate_d   = WAIT_CMD;
          end else if (timeout) begin
            pstate_d = WAIT_CMD;
          end
        end
        default: pstate_d = WAIT_CMD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pstate_q   <= WAIT_CMD;
      cmd_hold   <= 8'h00;
      comando_rx <= 8'h00;
      datos_rx   <= 8'h00;
      valid      <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      pstate_q <= pstate_d;

      if (pstate_q == WAIT_CMD && byte_ok)
        cmd_hold <= rx_byte;

      // An ack in the same cycle frees the slot, so the new frame still loads.
      if (frame_done && (!valid || clr)) begin
        valid      <= 1'b1;
        comando_rx <= cmd_hold;
        datos_rx   <= rx_byte;
      end else if (clr) begin
        valid <= 1'b0;
      end

      if (frame_done && valid && !clr)
        overrun <= 1'b1;
      else if (clr)
        overrun <= 1'b0;

      if (stop_err)
        frame_err <= 1'b1;
      else if (clr)
        frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_recibir_trama.sv
// Bench for recibir_trama with a 16-clock bit period.
// Expected frames are queued as they are sent and compared when valid rises.
// Define RECIBIR_TRAMA_TIMEOUT_EN to exercise the inter-byte timeout.
module tb_recibir_trama;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst, rx, ack;
  logic [7:0] comando_rx, datos_rx;
  logic       valid, overrun, frame_err, bussy;

  int total = 0;
  int bad   = 0;
  logic [15:0] sb[$];
  logic        valid_prev = 1'b0;

  always #5 clk = ~clk;

  recibir_trama #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(20)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .ack        (ack),
    .comando_rx (comando_rx),
    .datos_rx   (datos_rx),
    .valid      (valid),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .bussy      (bussy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_lvl);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_lvl;
    tick(CPB);
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] d, input bit expect_out);
    if (expect_out) sb.push_back({c, d});
    send_byte(c, 1'b1);
    send_byte(d, 1'b1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      tick(1);
      n++;
    end
    check("sb_drain", sb.size(), 0);
    tick(2);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    @(negedge clk);
  endtask

  // Scoreboard: every rising valid must match the oldest queued frame.
  always @(negedge clk) begin
    if (valid && !valid_prev) begin
      if (sb.size() == 0) begin
        check("frame_unexpected", {comando_rx, datos_rx}, 16'h0000);
      end else begin
        logic [15:0] e;
        e = sb.pop_front();
        check("frame_cmd", comando_rx, e[15:8]);
        check("frame_dat", datos_rx, e[7:0]);
      end
    end
    valid_prev = valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    rx  = 1'b1;
    ack = 1'b0;
    tick(3);
    check("rst_valid", valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_bussy", bussy, 0);
    check("rst_cmd", comando_rx, 8'h00);
    check("rst_dat", datos_rx, 8'h00);
    rst = 1'b1;
    tick(CPB);

    // Basic back-to-back frame and acknowledge.
    send_frame(8'hA5, 8'h3C, 1'b1);
    wait_drain();
    check("a5_valid", valid, 1);
    check("a5_overrun", overrun, 0);
    check("a5_frame_err", frame_err, 0);
    check("a5_bussy", bussy, 0);
    pulse_ack();
    check("a5_ack_valid", valid, 0);

    // Short low glitch is a false start.
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(2);
    check("glitch_busy", bussy, 1);
    tick(30);
    check("glitch_idle", bussy, 0);
    check("glitch_valid", valid, 0);

    // Bad stop bit: byte discarded, sticky frame_err, next frame fine.
    send_byte(8'h11, 1'b0);
    tick(2 * CPB);
    check("ferr_set", frame_err, 1);
    check("ferr_parser_reset", bussy, 0);
    check("ferr_no_valid", valid, 0);
    send_frame(8'h22, 8'h33, 1'b1);
    wait_drain();
    check("ferr_sticky", frame_err, 1);
    pulse_ack();
    check("ferr_cleared", frame_err, 0);

    // Overrun: second frame lost while the first is unacknowledged.
    send_frame(8'h01, 8'h02, 1'b1);
    wait_drain();
    send_frame(8'h03, 8'h04, 1'b0);
    tick(4);
    check("ovr_valid", valid, 1);
    check("ovr_cmd_kept", comando_rx, 8'h01);
    check("ovr_dat_kept", datos_rx, 8'h02);
    check("ovr_flag", overrun, 1);
    pulse_ack();
    check("ovr_ack_valid", valid, 0);
    check("ovr_ack_flag", overrun, 0);
    send_frame(8'h05, 8'h06, 1'b1);
    wait_drain();

    // Reset in the middle of bit 4 of a byte (05/06 still held).
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = 1'($unsigned(8'h7E) >> i);
      tick(CPB);
    end
    rx = 1'b1;
    tick(CPB / 2);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", valid, 0);
    check("mid_rst_cmd", comando_rx, 8'h00);
    check("mid_rst_dat", datos_rx, 8'h00);
    check("mid_rst_bussy", bussy, 0);
    tick(3);
    rx  = 1'b1;
    rst = 1'b1;
    tick(2 * CPB);
    send_frame(8'h7E, 8'h81, 1'b1);
    wait_drain();
    pulse_ack();

    // Lone command byte followed by a long idle gap.
`ifdef RECIBIR_TRAMA_TIMEOUT_EN
    send_byte(8'hAA, 1'b1);
    tick(400);
    check("to_dropped", bussy, 0);
    send_frame(8'hBB, 8'hCC, 1'b1);
    wait_drain();
    check("to_end_idle", bussy, 0);
`else
    sb.push_back(16'hAABB);
    send_byte(8'hAA, 1'b1);
    tick(400);
    check("noto_held", bussy, 1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    wait_drain();
    check("noto_cc_held", bussy, 1);
`endif
    pulse_ack();
    check("final_valid", valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
